// File: rtl/cm42_rr_sequencer_if.sv
// Handshake bundle between the ten requesters and the CM42 round-robin
// sequencer. The requester side drives req; the sequencer side drives the
// registered grant, BCD code, active-low select and status.
interface cm42_rr_sequencer_if;
    logic [9:0] req;
    logic       gnt_valid;
    logic [3:0] gnt_code;
    logic [9:0] sel_n;
    logic       busy_other;

    modport master (
        output req,
        input  gnt_valid,
        input  gnt_code,
        input  sel_n,
        input  busy_other
    );

    modport slave (
        input  req,
        output gnt_valid,
        output gnt_code,
        output sel_n,
        output busy_other
    );
endinterface

// File: rtl/cm42_rr_sequencer.sv
// Round-robin arbiter and sequencer for the shared active-low one-of-ten
// BCD select resource. One requester holds the resource at a time, a hold
// limit forces release when others wait, and every handover passes through
// a one-cycle all-deselected gap (break-before-make).
module cm42_rr_sequencer #(
    parameter int unsigned NREQ     = 10,
    parameter logic [3:0]  MAX_HOLD = 4'd8
) (
    input logic           clk,
    input logic           rst_n,
    cm42_rr_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic [3:0]      hold_q, hold_d;
    logic [3:0]      last_q, last_d;
    logic [NREQ-1:0] sel_n_q, sel_n_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [3:0]      winner;
    logic [4:0]      arb_sum;
    logic [NREQ-1:0] cur_mask;
    logic [NREQ-1:0] next_mask;
    logic            others;

    // Rotating search: first set req starting at last_ptr+1, wrapping 9 -> 0.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        found   = 1'b0;
        winner  = 4'd0;
        arb_sum = 5'd0;
        for (int i = 0; i < NREQ; i++) begin
            arb_sum = {1'b0, last_q} + 5'(i) + 5'd1;
            if (arb_sum >= 5'(NREQ)) begin
                arb_sum = arb_sum - 5'(NREQ);
            end
            if (!found && bus.req[arb_sum[3:0]]) begin
                found  = 1'b1;
                winner = arb_sum[3:0];
            end
        end
    end

    // Requests pending from anyone other than the current holder.
    always_comb begin
        cur_mask = valid_q ? (ONE_HOT0 << code_q) : '0;
        others   = |(bus.req & ~cur_mask);
    end

    // Next-state logic for the IDLE / GRANT / GAP sequencer.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            ST_GRANT: begin
                if (!bus.req[code_q] || (hold_q == MAX_HOLD && others)) begin
                    state_d = ST_GAP;
                    valid_d = 1'b0;
                    code_d  = 4'd0;
                    hold_d  = 4'd0;
                end else if (hold_q != MAX_HOLD) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                // IDLE and GAP share the same arbitration; GAP never lasts
                // more than one cycle because it always leaves from here.
                if (found) begin
                    state_d = ST_GRANT;
                    valid_d = 1'b1;
                    code_d  = winner;
                    hold_d  = 4'd1;
                    last_d  = winner;
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    code_d  = 4'd0;
                    hold_d  = 4'd0;
                end
            end
        endcase
    end

    // Decode the select and status from the next grant so the registered
    // outputs line up with the registered code in the same cycle.
    always_comb begin
        next_mask = valid_d ? (ONE_HOT0 << code_d) : '0;
        sel_n_d   = ~next_mask;
        busy_d    = |(bus.req & ~next_mask);
    end

    // State and output registers; reset clears any grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            hold_q  <= 4'd0;
            last_q  <= 4'd9;
            sel_n_q <= '1;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            sel_n_q <= sel_n_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt_valid  = valid_q;
    assign bus.gnt_code   = code_q;
    assign bus.sel_n      = sel_n_q;
    assign bus.busy_other = busy_q;

endmodule

// File: tb/tb_cm42_rr_sequencer.sv
// Scoreboard bench for cm42_rr_sequencer: stimulus pushes the hand-computed
// per-cycle grant expectation into a queue, a negedge monitor pops and
// compares it against the registered outputs.
module tb_cm42_rr_sequencer;

    typedef struct {
        int         due;
        logic       valid;
        logic [3:0] code;
        logic       chk_busy;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [9:0] one_hot;
    logic [9:0] exp_sel;

    cm42_rr_sequencer_if bus();

    cm42_rr_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive one cycle of req and queue the outputs expected after it is sampled.
    task automatic step(input logic [9:0] r, input logic v, input logic [3:0] c,
                        input logic cb, input logic b);
        exp_t e;
        bus.req    = r;
        e.due      = cyc + 1;
        e.valid    = v;
        e.code     = c;
        e.chk_busy = cb;
        e.busy     = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset with req cleared, releasing just after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        bus.req = 10'h000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.due < cyc) begin
                check("late_expectation", 32'(cyc), 32'(mon_e.due));
            end
            one_hot = 10'd1;
            exp_sel = mon_e.valid ? ~(one_hot << mon_e.code) : 10'h3FF;
            check("gnt_valid", 32'(bus.gnt_valid), 32'(mon_e.valid));
            check("gnt_code",  32'(bus.gnt_code),  32'(mon_e.code));
            check("sel_n",     32'(bus.sel_n),     32'(exp_sel));
            if (mon_e.chk_busy) begin
                check("busy_other", 32'(bus.busy_other), 32'(mon_e.busy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc     = 0;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        bus.req = 10'h3FF;

        // Reset held with every request high: nothing may be selected.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sel_n",      32'(bus.sel_n),      32'h3FF);
        check("reset_gnt_valid",  32'(bus.gnt_valid),  32'h0);
        check("reset_gnt_code",   32'(bus.gnt_code),   32'h0);
        check("reset_busy_other", 32'(bus.busy_other), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First search starts at index 0.
        step(10'h3FF, 1'b1, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);

        // Single request: code 3, then one gap, then idle.
        step(10'h008, 1'b1, 4'd3, 1'b0, 1'b0);
        step(10'h008, 1'b1, 4'd3, 1'b1, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b1, 1'b0);

        // Round robin over 0, 5, 9 from a fresh pointer: order 0,5,9,0.
        do_reset();
        step(10'h221, 1'b1, 4'd0, 1'b0, 1'b0);
        step(10'h221, 1'b1, 4'd0, 1'b0, 1'b0);
        step(10'h220, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h220, 1'b1, 4'd5, 1'b0, 1'b0);
        step(10'h220, 1'b1, 4'd5, 1'b0, 1'b0);
        step(10'h200, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h201, 1'b1, 4'd9, 1'b0, 1'b0);
        step(10'h201, 1'b1, 4'd9, 1'b0, 1'b0);
        step(10'h001, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h001, 1'b1, 4'd0, 1'b0, 1'b0);
        step(10'h001, 1'b1, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);

        // Hold limit: code 2 for exactly 8 cycles once req[7] waits.
        step(10'h004, 1'b1, 4'd2, 1'b0, 1'b0);
        step(10'h004, 1'b1, 4'd2, 1'b0, 1'b0);
        step(10'h084, 1'b1, 4'd2, 1'b0, 1'b0);
        for (int k = 4; k <= 8; k++) begin
            step(10'h084, 1'b1, 4'd2, 1'b1, 1'b1);
        end
        step(10'h084, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h084, 1'b1, 4'd7, 1'b0, 1'b0);
        step(10'h080, 1'b1, 4'd7, 1'b1, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);

        // Saturation: code 9 alone for 20 cycles, then wrap to code 1.
        step(10'h200, 1'b1, 4'd9, 1'b0, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            step(10'h200, 1'b1, 4'd9, 1'b1, 1'b0);
        end
        step(10'h202, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h202, 1'b1, 4'd1, 1'b0, 1'b0);
        step(10'h002, 1'b1, 4'd1, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset mid-grant of code 6: outputs clear immediately.
        step(10'h040, 1'b1, 4'd6, 1'b0, 1'b0);
        step(10'h040, 1'b1, 4'd6, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        bus.req = 10'h050;
        #1;
        check("midreset_sel_n",     32'(bus.sel_n),     32'h3FF);
        check("midreset_gnt_valid", 32'(bus.gnt_valid), 32'h0);
        check("midreset_gnt_code",  32'(bus.gnt_code),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Pointer back at 9, so code 4 wins over code 6.
        step(10'h050, 1'b1, 4'd4, 1'b0, 1'b0);
        step(10'h040, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h040, 1'b1, 4'd6, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(10'h000, 1'b0, 4'd0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
